equation_controller: RTL and testbench
======================================

// Module: equation_controller
// PURPOSE
// - Pipelined arithmetic block that evaluates one of two fixed equations per cycle, chosen by equationFlag.
//   - flag=0: A = x1*K1 + x2*K2
//   - flag=1: B = v*t + c
// - Sits between sensor/operand registers and the built-in self-test / downstream consumers.
// - A and B are held registers: only the selected result updates; the other holds its last value.
// PARAMETERS
// - W_IN   8   width of x1, x2, v, t, c
// - W_OUT  16  width of A and B; results truncated modulo 2^W_OUT
// - K1     3   constant coefficient for x1
// - K2     5   constant coefficient for x2
// PORTS
// - clk           in   1      single clock, rising edge
// - rst           in   1      synchronous, active-high reset
// - x1, x2        in   W_IN   equation-0 operands, unsigned
// - v, t, c       in   W_IN   equation-1 operands, unsigned
// - equationFlag  in   1      0 = compute A, 1 = compute B; sampled every cycle
// - A             out  W_OUT  registered result of equation 0
// - B             out  W_OUT  registered result of equation 1
// - a_upd         out  1      1-cycle strobe: A was written this cycle
// - b_upd         out  1      1-cycle strobe: B was written this cycle
// BEHAVIOUR
// - Reset (rst=1 at a rising edge) clears A, B, a_upd, b_upd, all pipeline registers and the stage-1 valid bit to 0.
// - Operation is continuous: a new operand set and flag are accepted every cycle. There is no handshake.
// - Operand mux feeds one shared sum-of-products unit, P = a*b + d*e:
//   - flag=0: a=x1, b=K1, d=x2, e=K2
//   - flag=1: a=v,  b=t,  d=c,  e=1
// - Stage 1 (edge n): register both products (each 2*W_IN bits), the flag, and valid=1.
// - Stage 2 (edge n+1):
//   - if valid and flag=0: A <= sum[W_OUT-1:0], a_upd=1, b_upd=0
//   - if valid and flag=1: B <= sum, b_upd=1, a_upd=0
//   - if valid=0: both strobes are 0 and A, B hold
// - Latency: 2 clocks from input sample to updated A/B. Throughput: 1 result per clock.
// - The flag travels with its data, so flag changes on consecutive cycles route each result to the correct output.
// - Width: the adder is W_OUT+1 bits wide internally, then truncated to W_OUT. With defaults there is no overflow:
//   - max A = 2040
//   - max B = 65280
// - Reset mid-operation flushes in-flight data: no strobe fires for operands sampled before reset. The first strobe appears 2 edges after rst falls.
// - Inputs are unsigned; there is no signed interpretation.
// STRUCTURE
// - Shared package eq_pkg:
//   - localparams W_IN, W_OUT, K1, K2
//   - enum eq_sel_t {EQ_A=0, EQ_B=1}
// - One sub-module, sop_unit: a*b + d*e with a registered product stage, parameterized on W_IN and W_OUT.
// - The top contains the operand mux, the flag/valid pipeline, and the A/B output registers.
// TESTING
// - Reset: hold rst 3 cycles with random operands -> A=0, B=0, a_upd=b_upd=0 throughout and on the first edge after release.
// - Eq0: flag=0, x1=2, x2=4 -> A=26 and a_upd=1 exactly 2 edges later; B unchanged.
// - Eq1: flag=1, v=10, t=20, c=7 -> B=207 and b_upd=1 2 edges later; A holds 26.
// - Extremes: all operands 255; flag=0 -> A=2040; flag=1 -> B=65280; all zeros -> 0.
// - Interleave: flag toggles 0,1,0,1 each cycle with distinct operands -> strobes alternate and each A/B value matches its own operand set.
// - Mid-flight reset: assert rst one cycle after driving flag=0, x1=1 -> A stays 0, no a_upd pulse; normal results resume 2 edges after release.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants and the equation selector for the equation controller.
// A = x1*K1 + x2*K2 (EQ_A), B = v*t + c (EQ_B).
package eq_pkg;
    localparam int W_IN  = 8;
    localparam int W_OUT = 16;
    localparam int K1    = 3;
    localparam int K2    = 5;

    typedef enum logic {
        EQ_A = 1'b0,
        EQ_B = 1'b1
    } eq_sel_t;
endpackage

// File: rtl/sop_unit.sv
// Sum of products P = a*b + d*e with a registered product stage.
// The sum is formed one bit wider than the result, then truncated.
module sop_unit #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_IN-1:0]  a,
    input  logic [W_IN-1:0]  b,
    input  logic [W_IN-1:0]  d,
    input  logic [W_IN-1:0]  e,
    output logic [W_OUT-1:0] sum
);
    localparam int P_W = 2 * W_IN;
    localparam int S_W = W_OUT + 1;

    logic [P_W-1:0] prod_ab_d, prod_ab_q;
    logic [P_W-1:0] prod_de_d, prod_de_q;

    always_comb begin
        prod_ab_d = P_W'(a) * P_W'(b);
        prod_de_d = P_W'(d) * P_W'(e);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_ab_q <= '0;
            prod_de_q <= '0;
        end else begin
            prod_ab_q <= prod_ab_d;
            prod_de_q <= prod_de_d;
        end
    end

    assign sum = W_OUT'(S_W'(prod_ab_q) + S_W'(prod_de_q));
endmodule

// File: rtl/equation_controller.sv
// Two-stage pipeline evaluating A = x1*K1 + x2*K2 or B = v*t + c per cycle.
// No handshake: one operand set is accepted every clock; the flag travels with its data.
module equation_controller
    import eq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W_IN-1:0]  x1,
    input  logic [W_IN-1:0]  x2,
    input  logic [W_IN-1:0]  v,
    input  logic [W_IN-1:0]  t,
    input  logic [W_IN-1:0]  c,
    input  logic             equationFlag,
    output logic [W_OUT-1:0] A,
    output logic [W_OUT-1:0] B,
    output logic             a_upd,
    output logic             b_upd
);
    logic [W_IN-1:0]  op_a, op_b, op_d, op_e;
    logic [W_OUT-1:0] sum;

    eq_sel_t          flag_d, flag_q;
    logic             valid_d, valid_q;
    logic [W_OUT-1:0] a_d, a_q;
    logic [W_OUT-1:0] b_d, b_q;
    logic             a_upd_d, a_upd_q;
    logic             b_upd_d, b_upd_q;

    // Both equations share one sum-of-products unit; eq1 uses d*e = c*1.
    always_comb begin
        op_a = x1;
        op_b = W_IN'(K1);
        op_d = x2;
        op_e = W_IN'(K2);
        if (equationFlag) begin
            op_a = v;
            op_b = t;
            op_d = c;
            op_e = W_IN'(1);
        end
    end

    sop_unit #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_sop (
        .clk (clk),
        .rst (rst),
        .a   (op_a),
        .b   (op_b),
        .d   (op_d),
        .e   (op_e),
        .sum (sum)
    );

    always_comb begin
        flag_d  = eq_sel_t'(equationFlag);
        valid_d = 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        a_upd_d = 1'b0;
        b_upd_d = 1'b0;
        if (valid_q) begin
            if (flag_q == EQ_A) begin
                a_d     = sum;
                a_upd_d = 1'b1;
            end else begin
                b_d     = sum;
                b_upd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q  <= EQ_A;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_upd_q <= 1'b0;
            b_upd_q <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_upd_q <= a_upd_d;
            b_upd_q <= b_upd_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign a_upd = a_upd_q;
    assign b_upd = b_upd_q;
endmodule

// File: tb/tb_equation_controller.sv
// Self-checking bench for equation_controller: arithmetic reference model with a
// one-deep result queue, per-cycle comparison, and literal directed expectations.
module tb_equation_controller;
    logic        clk;
    logic        rst;
    logic [7:0]  x1, x2, v, t, c;
    logic        equationFlag;
    logic [15:0] A, B;
    logic        a_upd, b_upd;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {flag, result}; presence in the queue means "valid in flight".
    logic [16:0] exp_q[$];
    logic [15:0] exp_a, exp_b;
    logic        exp_a_upd, exp_b_upd;

    equation_controller dut (
        .clk          (clk),
        .rst          (rst),
        .x1           (x1),
        .x2           (x2),
        .v            (v),
        .t            (t),
        .c            (c),
        .equationFlag (equationFlag),
        .A            (A),
        .B            (B),
        .a_upd        (a_upd),
        .b_upd        (b_upd)
    );

    // Clock and reset values
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result of a sample appears one edge after it is sampled.
    function automatic logic [15:0] eq_result(input logic f, input logic [7:0] a1, input logic [7:0] a2,
                                              input logic [7:0] vv, input logic [7:0] tt, input logic [7:0] cc);
        int r;
        if (f) r = int'(vv) * int'(tt) + int'(cc);
        else   r = int'(a1) * 3 + int'(a2) * 5;
        return 16'(r % 65536);
    endfunction

    always @(posedge clk) begin
        logic [16:0] ent;
        if (rst) begin
            exp_q.delete();
            exp_a     = '0;
            exp_b     = '0;
            exp_a_upd = 1'b0;
            exp_b_upd = 1'b0;
        end else begin
            exp_a_upd = 1'b0;
            exp_b_upd = 1'b0;
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                if (ent[16]) begin
                    exp_b     = ent[15:0];
                    exp_b_upd = 1'b1;
                end else begin
                    exp_a     = ent[15:0];
                    exp_a_upd = 1'b1;
                end
            end
            exp_q.push_back({equationFlag, eq_result(equationFlag, x1, x2, v, t, c)});
        end
        #1;
        check("model_A", A, exp_a);
        check("model_B", B, exp_b);
        check("model_a_upd", a_upd, exp_a_upd);
        check("model_b_upd", b_upd, exp_b_upd);
    end

    // Driver tasks
    task automatic set_in(input logic r, input logic f, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] vv, input logic [7:0] tt, input logic [7:0] cc);
        rst = r;
        equationFlag = f;
        x1 = a1;
        x2 = a2;
        v = vv;
        t = tt;
        c = cc;
    endtask

    task automatic set_random(input logic r);
        set_in(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        set_random(1'b1);
        // Reset held 3 cycles with random operands
        for (int i = 0; i < 3; i++) begin
            wait_neg(1);
            check("rst_A", A, 0);
            check("rst_B", B, 0);
            check("rst_a_upd", a_upd, 0);
            check("rst_b_upd", b_upd, 0);
            set_random(1'b1);
        end
        // Release with eq0 x1=2 x2=4 -> A=26
        set_in(1'b0, 1'b0, 8'd2, 8'd4, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        check("post_rst_a_upd", a_upd, 0);
        check("post_rst_b_upd", b_upd, 0);
        check("post_rst_A", A, 0);
        wait_neg(1);
        check("eq0_A", A, 26);
        check("eq0_a_upd", a_upd, 1);
        check("eq0_B", B, 0);

        set_in(1'b0, 1'b1, 8'd0, 8'd0, 8'd10, 8'd20, 8'd7);
        wait_neg(2);
        check("eq1_B", B, 207);
        check("eq1_b_upd", b_upd, 1);
        check("eq1_A_hold", A, 26);

        // Extremes
        set_in(1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        wait_neg(2);
        check("max_A", A, 2040);
        set_in(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        wait_neg(2);
        check("max_B", B, 65280);
        check("max_A_hold", A, 2040);
        set_in(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_neg(2);
        check("zero_A", A, 0);
        set_in(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_neg(2);
        check("zero_B", B, 0);

        // Interleave: 8, 10, 130, 30
        set_in(1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        set_in(1'b0, 1'b1, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4);
        wait_neg(1);
        check("il_A0", A, 8);
        check("il_a_upd0", a_upd, 1);
        set_in(1'b0, 1'b0, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        check("il_B1", B, 10);
        check("il_b_upd1", b_upd, 1);
        set_in(1'b0, 1'b1, 8'd0, 8'd0, 8'd5, 8'd5, 8'd5);
        wait_neg(1);
        check("il_A2", A, 130);
        check("il_b_upd2", b_upd, 0);
        wait_neg(1);
        check("il_B3", B, 30);
        check("il_A3_hold", A, 130);

        // Mid-flight reset flushes eq0 x1=1
        set_in(1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        set_in(1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        check("mf_A", A, 0);
        check("mf_a_upd", a_upd, 0);
        set_in(1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_neg(1);
        check("mf_first_a_upd", a_upd, 0);
        check("mf_first_A", A, 0);
        wait_neg(1);
        check("mf_resume_A", A, 9);
        check("mf_resume_a_upd", a_upd, 1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            set_random(1'($urandom_range(0, 31) == 0));
            wait_neg(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
